// File: rtl/spi_slave_seq_pkg.sv
// Register map, state encoding and shared helpers for the spi_slave_seq sequencer.
// Optional interrupt-driven mode is selected with the SPI_SEQ_IRQ_EN macro.
`ifndef SPI_DATA_W
`define SPI_DATA_W 8
`endif
`ifndef SPI_ADDR_W
`define SPI_ADDR_W 3
`endif
`ifndef SPI_READY
`define SPI_READY 3'd1
`endif
`ifndef SPI_RX
`define SPI_RX 3'd2
`endif
`ifndef SPI_TX
`define SPI_TX 3'd3
`endif
`ifndef SPI_INTRRPT_EN
`define SPI_INTRRPT_EN 3'd4
`endif

package spi_slave_seq_pkg;
  localparam int DATA_W     = `SPI_DATA_W;
  localparam int ADDR_W     = `SPI_ADDR_W;
  localparam int DROP_CNT_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_READY   = `SPI_READY;
  localparam logic [ADDR_W-1:0] ADDR_RX      = `SPI_RX;
  localparam logic [ADDR_W-1:0] ADDR_TX      = `SPI_TX;
  localparam logic [ADDR_W-1:0] ADDR_INTR_EN = `SPI_INTRRPT_EN;

  typedef enum logic [2:0] {
    ST_INIT_TX  = 3'd0,
    ST_INIT_IRQ = 3'd1,
    ST_WAIT     = 3'd2,
    ST_POLL     = 3'd3,
    ST_RX       = 3'd4,
    ST_TX       = 3'd5
  } seq_state_e;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction
endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous RX FIFO with wrap-bit pointers; a pop in the same cycle frees room for a push when full.
module spi_seq_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {(DEPTH_LOG2+1){1'b0}};
      rd_ptr <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/spi_slave_seq.sv
// Sequencer driving the SPI slave register bus: reloads TX, detects frames, drains RX into a FIFO.
// Define SPI_SEQ_IRQ_EN to wait on spi_interrupt instead of polling READY.
module spi_slave_seq
  import spi_slave_seq_pkg::*;
#(
  parameter int                RX_DEPTH_LOG2 = 2,
  parameter int                POLL_GAP      = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD     = {DATA_W{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [ADDR_W-1:0]     spi_addr,
  output logic                  spi_sel,
  output logic                  spi_read,
  output logic                  spi_write,
  output logic [DATA_W-1:0]     spi_wdata,
  input  logic [DATA_W-1:0]     spi_rdata,
  input  logic                  spi_interrupt
);
  seq_state_e        state;
  seq_state_e        state_nx;
  // Low for the first cycle after reset so the bus is quiet before INIT_TX issues its write.
  logic              armed;
  logic              sel_dec;
  logic              read_dec;
  logic              write_dec;
  logic              take_dec;
  logic [ADDR_W-1:0] addr_dec;
  logic [DATA_W-1:0] wdata_dec;
  logic              rx_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wait_done;

`ifdef SPI_SEQ_IRQ_EN
  assign wait_done = spi_interrupt;
`else
  localparam int POLL_W = $clog2(POLL_GAP) + 1;
  logic [POLL_W-1:0] poll_cnt;
  logic              unused_irq;

  assign unused_irq = spi_interrupt;
  assign wait_done  = (poll_cnt == POLL_W'(POLL_GAP - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt <= {POLL_W{1'b0}};
    end else if (armed && (state == ST_WAIT) && !wait_done) begin
      poll_cnt <= poll_cnt + POLL_W'(1);
    end else begin
      poll_cnt <= {POLL_W{1'b0}};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT_TX;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (!armed) begin
      state_nx = ST_INIT_TX;
    end else begin
      case (state)
`ifdef SPI_SEQ_IRQ_EN
        ST_INIT_TX:  state_nx = ST_INIT_IRQ;
        ST_WAIT:     state_nx = wait_done ? ST_RX : ST_WAIT;
`else
        ST_INIT_TX:  state_nx = ST_WAIT;
        ST_WAIT:     state_nx = wait_done ? ST_POLL : ST_WAIT;
`endif
        ST_INIT_IRQ: state_nx = ST_WAIT;
        ST_POLL:     state_nx = spi_rdata[0] ? ST_RX : ST_WAIT;
        ST_RX:       state_nx = ST_TX;
        ST_TX:       state_nx = ST_WAIT;
        default:     state_nx = ST_INIT_TX;
      endcase
    end
  end

  always_comb begin
    sel_dec   = 1'b0;
    read_dec  = 1'b0;
    write_dec = 1'b0;
    take_dec  = 1'b0;
    addr_dec  = {ADDR_W{1'b0}};
    wdata_dec = {DATA_W{1'b0}};
    case (state)
      ST_INIT_TX, ST_TX: begin
        sel_dec   = 1'b1;
        write_dec = 1'b1;
        addr_dec  = ADDR_TX;
        wdata_dec = tx_valid ? tx_data : IDLE_WORD;
        take_dec  = tx_valid;
      end
`ifdef SPI_SEQ_IRQ_EN
      ST_INIT_IRQ: begin
        sel_dec   = 1'b1;
        write_dec = 1'b1;
        addr_dec  = ADDR_INTR_EN;
        wdata_dec = DATA_W'(1);
      end
`endif
      ST_POLL: begin
        sel_dec  = 1'b1;
        read_dec = 1'b1;
        addr_dec = ADDR_READY;
      end
      ST_RX: begin
        sel_dec  = 1'b1;
        read_dec = 1'b1;
        addr_dec = ADDR_RX;
      end
      default: begin
        sel_dec = 1'b0;
      end
    endcase
  end

  assign spi_sel   = armed & sel_dec;
  assign spi_read  = armed & read_dec;
  assign spi_write = armed & write_dec;
  assign tx_ready  = armed & take_dec;
  assign spi_addr  = armed ? addr_dec  : {ADDR_W{1'b0}};
  assign spi_wdata = armed ? wdata_dec : {DATA_W{1'b0}};

  // The RX read word is captured on the same edge that ends the access.
  assign rx_push  = armed && (state == ST_RX);
  assign rx_valid = !fifo_empty;

  spi_seq_fifo #(
    .WIDTH      (DATA_W),
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (spi_rdata),
    .pop   (rx_ready),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= {DROP_CNT_W{1'b0}};
    end else if (rx_push && fifo_full && !(rx_ready && !fifo_empty)) begin
      drop_cnt <= sat_inc(drop_cnt);
    end else begin
      drop_cnt <= drop_cnt;
    end
  end
endmodule

// File: tb/tb_spi_slave_seq.sv
// Self-checking bench for spi_slave_seq: directed table, hand sequences and a randomized queue model.
module tb_spi_slave_seq;
  import spi_slave_seq_pkg::*;

  localparam int                POLL_GAP = 8;
  localparam logic [DATA_W-1:0] IDLE     = {DATA_W{1'b0}};

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [DATA_W-1:0]     tx_data = {DATA_W{1'b0}};
  logic                  tx_valid = 1'b0;
  logic                  tx_ready;
  logic [DATA_W-1:0]     rx_data;
  logic                  rx_valid;
  logic                  rx_ready = 1'b0;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic [ADDR_W-1:0]     spi_addr;
  logic                  spi_sel;
  logic                  spi_read;
  logic                  spi_write;
  logic [DATA_W-1:0]     spi_wdata;
  logic [DATA_W-1:0]     spi_rdata;
  logic                  spi_interrupt;

  int checks = 0;
  int failures = 0;

  spi_slave_seq #(.RX_DEPTH_LOG2(2), .POLL_GAP(POLL_GAP), .IDLE_WORD(IDLE)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .drop_cnt(drop_cnt),
    .spi_addr(spi_addr), .spi_sel(spi_sel), .spi_read(spi_read), .spi_write(spi_write),
    .spi_wdata(spi_wdata), .spi_rdata(spi_rdata), .spi_interrupt(spi_interrupt)
  );

  always #5 clk = ~clk;

  // Slave model: a frame raises READY (and the interrupt); reading RX clears it.
  logic              ready_flag = 1'b0;
  logic              inject = 1'b0;
  logic [DATA_W-1:0] rx_word = {DATA_W{1'b0}};

  always @(posedge clk) begin
    if (spi_sel && spi_read && spi_addr == ADDR_RX) ready_flag <= 1'b0;
    else if (inject) ready_flag <= 1'b1;
  end

  assign spi_rdata = (spi_addr == ADDR_READY) ? {{(DATA_W-1){1'b0}}, ready_flag} :
                     (spi_addr == ADDR_RX) ? rx_word : {DATA_W{1'b0}};
  assign spi_interrupt = ready_flag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset sel", spi_sel, 1'b0);
    chk("reset rd_wr", {spi_read, spi_write}, 2'b00);
    chk("reset addr", spi_addr, 0);
    chk("reset wdata", spi_wdata, 0);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset drop_cnt", drop_cnt, 0);
    chk("reset tx_ready", tx_ready, 1'b0);
    rst = 1'b0;
  endtask

  task automatic next_access(output int gap, output logic rd, output logic wr,
                             output logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] wd,
                             output logic tr);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!spi_sel && gap < 100);
    if (!spi_sel) chk("access timeout", 1'b0, 1'b1);
    rd = spi_read;
    wr = spi_write;
    a  = spi_addr;
    wd = spi_wdata;
    tr = tx_ready;
  endtask

  task automatic wait_rx(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(spi_sel && spi_read && spi_addr == ADDR_RX) && n < 64);
    chk({name, " rx_read"}, spi_sel && spi_read && spi_addr == ADDR_RX, 1'b1);
  endtask

  // Injects one frame and returns at the negedge of the TX reload that follows the RX read.
  task automatic frame(input logic [DATA_W-1:0] w, input logic pop_at_rx, input string name);
    inject  = 1'b1;
    rx_word = w;
    @(posedge clk);
    #1 inject = 1'b0;
    wait_rx(name);
    rx_ready = pop_at_rx;
    @(negedge clk);
    rx_ready = 1'b0;
    chk({name, " tx_write"}, spi_sel && spi_write && spi_addr == ADDR_TX, 1'b1);
  endtask

  typedef struct {
    logic              tv;
    logic [DATA_W-1:0] td;
    logic [DATA_W-1:0] rw;
    logic [DATA_W-1:0] exp_wd;
    logic              exp_tr;
  } vec_t;

  vec_t vecs[5];

  int                gap;
  logic              a_rd, a_wr, a_tr;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wd;
  logic [DATA_W-1:0] q[$];
  int                mdrop;
  logic              do_pop, do_push, tx_taken, is_txw;
  logic [DATA_W-1:0] pw;

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 1'b1};
    vecs[1] = '{1'b0, 8'h77, 8'h01, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 8'hFF, 8'h80, 8'hFF, 1'b1};
    vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b0};
    repeat (2) @(negedge clk);

    // Idle startup: one TX load of the idle word, then the steady poll/interrupt pattern.
    do_reset();
    next_access(gap, a_rd, a_wr, a_addr, a_wd, a_tr);
    chk("init write", {a_rd, a_wr}, 2'b01);
    chk("init addr", a_addr, ADDR_TX);
    chk("init wdata idle", a_wd, IDLE);
    chk("init tx_ready", a_tr, 1'b0);
`ifdef SPI_SEQ_IRQ_EN
    next_access(gap, a_rd, a_wr, a_addr, a_wd, a_tr);
    chk("irq en addr", a_addr, ADDR_INTR_EN);
    chk("irq en write", {a_rd, a_wr}, 2'b01);
    chk("irq en data", a_wd, 1);
    chk("irq en gap", gap, 1);
    gap = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (spi_sel) gap++;
    end
    chk("irq no polls", gap, 0);
    inject  = 1'b1;
    rx_word = 8'h5A;
    @(posedge clk);
    #1 inject = 1'b0;
    @(negedge clk);
    chk("irq wait quiet", spi_sel, 1'b0);
    @(negedge clk);
    chk("irq rx next", spi_sel && spi_read && spi_addr == ADDR_RX, 1'b1);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
`else
    for (int i = 0; i < 3; i++) begin
      next_access(gap, a_rd, a_wr, a_addr, a_wd, a_tr);
      chk("poll gap", gap, POLL_GAP + 1);
      chk("poll addr", a_addr, ADDR_READY);
      chk("poll read", {a_rd, a_wr}, 2'b10);
      chk("poll rx_valid", rx_valid, 1'b0);
    end
`endif

    // A host word waiting at reset is consumed by the initial TX load.
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    do_reset();
    next_access(gap, a_rd, a_wr, a_addr, a_wd, a_tr);
    chk("init host addr", a_addr, ADDR_TX);
    chk("init host wdata", a_wd, 8'hA5);
    chk("init host tx_ready", a_tr, 1'b1);
    tx_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tx_valid = vecs[i].tv;
      tx_data  = vecs[i].td;
      frame(vecs[i].rw, 1'b0, "vec");
      chk("vec wdata", spi_wdata, vecs[i].exp_wd);
      chk("vec tx_ready", tx_ready, vecs[i].exp_tr);
      chk("vec rx_valid", rx_valid, 1'b1);
      chk("vec rx_data", rx_data, vecs[i].rw);
      tx_valid = 1'b0;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk("vec drained", rx_valid, 1'b0);
    end

    // Overflow: six frames into a four-deep FIFO with no pops.
    for (int i = 1; i <= 6; i++) frame(DATA_W'(i), 1'b0, "ovf");
    chk("ovf drop_cnt", drop_cnt, 2);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf rx_valid", rx_valid, 1'b1);
      chk("ovf pop data", rx_data, k);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    chk("ovf empty", rx_valid, 1'b0);

    // Full FIFO with a host pop on the push edge: no drop, new word at the tail.
    for (int i = 10; i <= 13; i++) frame(DATA_W'(i), 1'b0, "full");
    frame(8'd14, 1'b1, "fullpop");
    chk("fullpop drop_cnt", drop_cnt, 2);
    chk("fullpop head", rx_data, 11);
    frame(8'd15, 1'b0, "fullchk");
    chk("fullchk drop_cnt", drop_cnt, 3);
    for (int k = 11; k <= 14; k++) begin
      chk("fullpop order", rx_data, k);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    chk("fullpop empty", rx_valid, 1'b0);

    // Reset landing on the TX reload.
    frame(8'h55, 1'b0, "midrst");
    rst = 1'b1;
    @(negedge clk);
    chk("midrst strobes", {spi_sel, spi_read, spi_write}, 3'b000);
    chk("midrst rx_valid", rx_valid, 1'b0);
    chk("midrst drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    next_access(gap, a_rd, a_wr, a_addr, a_wd, a_tr);
    chk("midrst restart addr", a_addr, ADDR_TX);
    chk("midrst restart write", {a_rd, a_wr}, 2'b01);
    chk("midrst restart gap", gap, 1);

    // Randomized traffic against a queue model of the FIFO and drop counter.
    do_reset();
    q.delete();
    mdrop = 0;
    tx_taken = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      chk("rand rx_valid", rx_valid, q.size() > 0);
      if (q.size() > 0) chk("rand rx_data", rx_data, q[0]);
      chk("rand drop_cnt", drop_cnt, mdrop);
      if (tx_taken) tx_valid = 1'b0;
      if (!tx_valid && $urandom_range(0, 3) == 0) begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'($urandom);
      end
      rx_ready = ($urandom_range(0, 2) == 0);
      inject   = 1'b0;
      if (!ready_flag && $urandom_range(0, 5) == 0) begin
        inject  = 1'b1;
        rx_word = DATA_W'($urandom);
      end
      #1;
      is_txw = spi_sel && spi_write && spi_addr == ADDR_TX;
      if (is_txw) begin
        chk("rand tx wdata", spi_wdata, tx_valid ? tx_data : IDLE);
        chk("rand tx_ready", tx_ready, tx_valid);
      end else begin
        chk("rand tx_ready idle", tx_ready, 1'b0);
      end
      tx_taken = is_txw && tx_valid;
      do_pop   = rx_ready && q.size() > 0;
      do_push  = spi_sel && spi_read && spi_addr == ADDR_RX;
      pw       = spi_rdata;
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (q.size() < 4) q.push_back(pw);
        else mdrop = (mdrop == 255) ? 255 : mdrop + 1;
      end
    end
    inject   = 1'b0;
    rx_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
